row_max_normalizer: RTL and testbench
=====================================

Name: row_max_normalizer

Overview:
- Consumer stage directly downstream of the max reduction tree in the softmax datapath.
- Collects one row of N-lane beats, each carrying the tree's per-beat maximum plus the bypassed raw lanes, and folds the per-beat maxima into a row maximum.
- Buffers the raw lanes, then replays them as x - row_max (saturated Q6.10) to the exponent stage with a valid/ready handshake.

Parameters:
- N, 8, lanes per beat; must match the reduction tree width.
- DEPTH, 4, maximum beats per row held in the internal buffer; power of two, >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; low freezes all state.
- in_valid  input  1  beat present; driven by the tree's MAX-valid.
- in_max  input  16  signed Q6.10 maximum of this beat.
- in_lane_valid  input  N  bypassed per-lane valid bits.
- in_lanes  input  N*16  bypassed raw lanes; lane i at [i*16 +: 16], signed Q6.10.
- in_last  input  1  marks the final beat of a row.
- in_ready  output  1  block accepts a beat this cycle.
- out_valid  output  1  normalized beat available.
- out_ready  input  1  downstream accepts the beat.
- out_lanes  output  N*16  signed Q6.10 normalized lanes.
- out_lane_valid  output  N  lane valids replayed from the buffer.
- out_last  output  1  high on the final replayed beat of the row.
- row_max  output  16  row maximum; held stable from the end of FILL through DRAIN.
- err_overflow  output  1  one-cycle pulse; the DEPTH-th beat arrived without in_last.

Behaviour:
- Reset (rst low, asynchronous):
  - state = FILL; write/read pointers and beat count = 0; buffer = 0.
  - row_max = 0, out_valid = 0, out_last = 0, err_overflow = 0.
  - out_lanes and out_lane_valid read 0.
- Reset asserted mid-row discards the partial row.
- en = 0:
  - All registers hold.
  - in_ready = 0 and out_valid = 0; no transfers occur.
- FILL state:
  - in_ready = en.
  - A beat is accepted when in_valid & in_ready. The accepted beat is written into buffer[wr_ptr] (lanes plus lane valids), then wr_ptr increments.
  - Running max update: on the first beat of a row, run_max = in_max. On later beats, run_max = max(run_max, in_max) using a signed compare; on a tie keep run_max.
  - Row end: an accepted beat with in_last = 1, or the DEPTH-th accepted beat. The DEPTH-th beat forces row end whether or not in_last is set.
  - If the DEPTH-th beat has in_last = 0, err_overflow pulses for 1 cycle in the following cycle. The next row starts fresh.
  - On row end:
    - row_max is latched including the final beat.
    - nbeats is set to the number of beats accepted.
    - State becomes DRAIN on the next edge.
    - in_ready drops in the cycle after the final accept.
- DRAIN state:
  - in_ready = 0; out_valid = en.
  - Outputs are combinational from buffer[rd_ptr] and row_max.
  - Latency: last input accept at edge t gives out_valid = 1 in the cycle after t.
  - Each lane: diff = sext17(x_i) - sext17(row_max), saturated to [0x8000, 0x7FFF].
  - Lanes with out_lane_valid[i] = 0 output 0x8000 (forces exp to ~0).
  - out_last = 1 when rd_ptr == nbeats-1.
  - A pop happens on out_valid & out_ready; rd_ptr then increments.
  - out_valid held with out_ready = 0: all outputs stay stable.
  - Pop of the last beat returns to FILL on the next edge, with pointers and count cleared. in_ready = 1 in that next cycle (if en = 1).
- The single buffer means FILL and DRAIN never overlap; back-pressure reaches the tree through in_ready.
- Single-beat row (in_last on the first beat): nbeats = 1, and the one replayed beat has out_last = 1.

Test Plan:
- Two-beat row:
  - Stimulus: beat0 max=0x0400, lanes all 0x0400; beat1 max=0x0800 with in_last, lanes all 0x0200.
  - Response: row_max = 0x0800; out beat0 lanes = 0xFC00; out beat1 lanes = 0xFA00 with out_last = 1; in_ready returns 1 one cycle after the second pop.
- Saturation:
  - Stimulus: lane = 0x8000 (-32.0), row_max = 0x7C00 (+31.0).
  - Response: out lane = 0x8000, not wrapped.
- Invalid lane:
  - Stimulus: in_lane_valid = 0xFE, lane0 = 0x0100.
  - Response: out lane0 = 0x8000; out_lane_valid = 0xFE.
- Overflow:
  - Stimulus: DEPTH = 4 beats with in_last = 0 throughout, beat maxima 0x0100, 0xFF00, 0x0300, 0x0200.
  - Response: err_overflow pulses once; row_max = 0x0300; 4 beats drained, the 4th with out_last.
- Back-pressure and en:
  - Stimulus: out_ready low for 3 cycles during DRAIN, then en low for 2 cycles.
  - Response: out_lanes stable and no pointer advance; out_valid = 0 while en = 0; drain resumes intact.
- Async reset mid-DRAIN:
  - Stimulus: assert rst low between clock edges.
  - Response: out_valid = 0 and row_max = 0 immediately; after release, in_ready = 1 and a fresh single-beat row drains correctly.

Source files
------------

// File: rtl/row_max_normalizer.sv
// Softmax row stage: folds per-beat maxima from the reduction tree into a row maximum,
// buffers the raw lanes, then replays them as saturated (x - row_max) in Q6.10.
module row_max_normalizer #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [15:0]      in_max,
  input  logic [N-1:0]     in_lane_valid,
  input  logic [N*16-1:0]  in_lanes,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*16-1:0]  out_lanes,
  output logic [N-1:0]     out_lane_valid,
  output logic             out_last,
  output logic [15:0]      row_max,
  output logic             err_overflow
);

  localparam int unsigned W  = 16;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   nbeats_q, nbeats_d;
  logic [W-1:0]    run_max_q, run_max_d;
  logic [W-1:0]    row_max_q, row_max_d;
  logic            err_q, err_d;

  logic [N*W-1:0]  buf_lanes_q [DEPTH];
  logic [N-1:0]    buf_lv_q    [DEPTH];

  logic            draining;
  logic            accept;
  logic            pop;
  logic            row_full;
  logic            last_beat;
  logic [W-1:0]    beat_max;

  assign draining  = (state_q == DRAIN);
  assign in_ready  = en & ~draining;
  assign out_valid = en & draining;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign row_full  = (wr_ptr_q == AW'(DEPTH - 1));
  assign last_beat = ({1'b0, rd_ptr_q} == (nbeats_q - CW'(1)));

  // First beat seeds the running max; later beats replace it only when strictly larger.
  assign beat_max = ((wr_ptr_q == '0) || ($signed(in_max) > $signed(run_max_q)))
                    ? in_max : run_max_q;

  // Next-state and control.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    nbeats_d  = nbeats_q;
    run_max_d = run_max_q;
    row_max_d = row_max_q;
    err_d     = en ? 1'b0 : err_q;

    if (accept) begin
      run_max_d = beat_max;
      wr_ptr_d  = wr_ptr_q + AW'(1);
      if (in_last || row_full) begin
        row_max_d = beat_max;
        nbeats_d  = CW'(wr_ptr_q) + CW'(1);
        state_d   = DRAIN;
        err_d     = row_full & ~in_last;
      end
    end

    if (pop) begin
      if (last_beat) begin
        state_d  = FILL;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        nbeats_d = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      nbeats_q  <= '0;
      run_max_q <= '0;
      row_max_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_lanes_q[i] <= '0;
        buf_lv_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      nbeats_q  <= nbeats_d;
      run_max_q <= run_max_d;
      row_max_q <= row_max_d;
      err_q     <= err_d;
      if (accept) begin
        buf_lanes_q[wr_ptr_q] <= in_lanes;
        buf_lv_q[wr_ptr_q]    <= in_lane_valid;
      end
    end
  end

  // Per-lane 17-bit difference saturated back to Q6.10; invalid lanes pinned to the minimum.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] x;
    logic [W:0]   diff;
    logic [W-1:0] sat;

    assign x    = buf_lanes_q[rd_ptr_q][i*W +: W];
    assign diff = {x[W-1], x} - {row_max_q[W-1], row_max_q};
    assign sat  = (diff[W] != diff[W-1]) ? (diff[W] ? SAT_MIN : SAT_MAX) : diff[W-1:0];
    assign out_lanes[i*W +: W] = !draining ? '0
                               : (buf_lv_q[rd_ptr_q][i] ? sat : SAT_MIN);
  end

  assign out_lane_valid = draining ? buf_lv_q[rd_ptr_q] : '0;
  assign out_last       = draining & last_beat;
  assign row_max        = row_max_q;
  assign err_overflow   = err_q;

endmodule

// File: tb/tb_row_max_normalizer.sv
// Directed bench for row_max_normalizer: fill/drain, saturation, invalid lanes,
// overflow, back-pressure with enable, and asynchronous reset mid-drain.
module tb_row_max_normalizer;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [15:0]      in_max;
  logic [N-1:0]     in_lane_valid;
  logic [N*16-1:0]  in_lanes;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [N*16-1:0]  out_lanes;
  logic [N-1:0]     out_lane_valid;
  logic             out_last;
  logic [15:0]      row_max;
  logic             err_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N*16-1:0] exp_lanes;

  row_max_normalizer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .in_valid       (in_valid),
    .in_max         (in_max),
    .in_lane_valid  (in_lane_valid),
    .in_lanes       (in_lanes),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lanes      (out_lanes),
    .out_lane_valid (out_lane_valid),
    .out_last       (out_last),
    .row_max        (row_max),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [15:0] mx, input logic [N*16-1:0] lanes,
                          input logic [N-1:0] lv, input logic last);
    in_valid      = 1'b1;
    in_max        = mx;
    in_lanes      = lanes;
    in_lane_valid = lv;
    in_last       = last;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    in_max        = '0;
    in_lanes      = '0;
    in_lane_valid = '0;
    in_last       = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    out_ready = 1'b0;
    idle_in();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_row_max", row_max, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_out_lanes", out_lanes, 0);
    chk("rst_out_lv", out_lane_valid, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Two-beat row.
    set_beat(16'h0400, {N{16'h0400}}, 8'hFF, 1'b0);
    chk("two_b0_ready", in_ready, 1);
    tick();
    set_beat(16'h0800, {N{16'h0200}}, 8'hFF, 1'b1);
    chk("two_b1_ready", in_ready, 1);
    tick();
    idle_in();
    chk("two_in_ready_drain", in_ready, 0);
    chk("two_out_valid", out_valid, 1);
    chk("two_row_max", row_max, 16'h0800);
    chk("two_o0_lanes", out_lanes, {N{16'hFC00}});
    chk("two_o0_last", out_last, 0);
    chk("two_o0_lv", out_lane_valid, 8'hFF);
    out_ready = 1'b1;
    tick();
    chk("two_o1_lanes", out_lanes, {N{16'hFA00}});
    chk("two_o1_last", out_last, 1);
    tick();
    out_ready = 1'b0;
    chk("two_ready_back", in_ready, 1);
    chk("two_valid_off", out_valid, 0);

    // Saturation to minimum and a plain negative difference, single-beat row.
    exp_lanes = {N{16'h7C00}};
    exp_lanes[15:0]  = 16'h8000;
    exp_lanes[31:16] = 16'h0100;
    set_beat(16'h7C00, exp_lanes, 8'hFF, 1'b1);
    tick();
    idle_in();
    exp_lanes = {N{16'h0000}};
    exp_lanes[15:0]  = 16'h8000;
    exp_lanes[31:16] = 16'h8500;
    chk("sat_lanes", out_lanes, exp_lanes);
    chk("sat_single_last", out_last, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sat_ready_back", in_ready, 1);

    // Invalid lane 0 plus saturation to maximum.
    exp_lanes = {N{16'h0000}};
    exp_lanes[15:0]  = 16'h0100;
    exp_lanes[31:16] = 16'h7FFF;
    exp_lanes[47:32] = 16'h8000;
    set_beat(16'h8000, exp_lanes, 8'hFE, 1'b1);
    tick();
    idle_in();
    exp_lanes = {N{16'h7FFF}};
    exp_lanes[15:0]  = 16'h8000;
    exp_lanes[47:32] = 16'h0000;
    chk("inv_lanes", out_lanes, exp_lanes);
    chk("inv_lv", out_lane_valid, 8'hFE);
    chk("inv_row_max", row_max, 16'h8000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Overflow: DEPTH beats without in_last.
    set_beat(16'h0100, {N{16'h0100}}, 8'hFF, 1'b0);
    tick();
    set_beat(16'hFF00, {N{16'hFF00}}, 8'hFF, 1'b0);
    tick();
    set_beat(16'h0300, {N{16'h0300}}, 8'hFF, 1'b0);
    tick();
    chk("ovf_err_before", err_overflow, 0);
    chk("ovf_ready_b3", in_ready, 1);
    set_beat(16'h0200, {N{16'h0200}}, 8'hFF, 1'b0);
    tick();
    idle_in();
    chk("ovf_err_pulse", err_overflow, 1);
    chk("ovf_row_max", row_max, 16'h0300);
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_o0_lanes", out_lanes, {N{16'hFE00}});
    // Back-pressure for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_lanes_stable", out_lanes, {N{16'hFE00}});
      chk("bp_out_valid", out_valid, 1);
      chk("bp_last", out_last, 0);
    end
    chk("ovf_err_cleared", err_overflow, 0);
    // Enable low for two cycles with downstream ready.
    en = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("en0_out_valid", out_valid, 0);
    chk("en0_in_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("en0_lanes_hold", out_lanes, {N{16'hFE00}});
      chk("en0_valid_hold", out_valid, 0);
    end
    en = 1'b1;
    #1;
    chk("resume_valid", out_valid, 1);
    chk("resume_o0", out_lanes, {N{16'hFE00}});
    tick();
    chk("ovf_o1", out_lanes, {N{16'hFC00}});
    tick();
    chk("ovf_o2", out_lanes, {N{16'h0000}});
    chk("ovf_o2_last", out_last, 0);
    tick();
    chk("ovf_o3", out_lanes, {N{16'hFF00}});
    chk("ovf_o3_last", out_last, 1);
    tick();
    out_ready = 1'b0;
    chk("ovf_ready_back", in_ready, 1);

    // Asynchronous reset while draining.
    set_beat(16'h0100, {N{16'h0080}}, 8'hFF, 1'b0);
    tick();
    set_beat(16'h0200, {N{16'h0100}}, 8'hFF, 1'b1);
    tick();
    idle_in();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_lanes", out_lanes, {N{16'hFF00}});
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_row_max", row_max, 0);
    chk("ar_out_lanes", out_lanes, 0);
    rst = 1'b1;
    #0.5;
    chk("ar_in_ready", in_ready, 1);
    tick();
    set_beat(16'h0A00, {N{16'h0900}}, 8'hFF, 1'b1);
    tick();
    idle_in();
    chk("ar_new_valid", out_valid, 1);
    chk("ar_new_row_max", row_max, 16'h0A00);
    chk("ar_new_lanes", out_lanes, {N{16'hFF00}});
    chk("ar_new_last", out_last, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ar_done_ready", in_ready, 1);
    chk("ar_done_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
